uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter between `NUM_REQ` byte sources, such as the loopback echo path and a status/message generator. It uses round-robin arbitration with message locking, so a granted source keeps the transmitter until it sends a byte flagged `last`. The block sits between the sources and the TX core: it drives the core's data-valid strobe and byte, and sequences on the core's done pulse.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..8).
- `TIMEOUT_CYCLES`, default 4340: idle cycles tolerated inside a locked message; 20 bit times at 217 clk/bit.
- `i_clk`  in  1  system clock (25 MHz).
- `i_reset`  in  1  reset; one clock, synchronous, active-high.
- `i_req_valid`  in  NUM_REQ  per-source byte available.
- `i_req_byte`  in  8*NUM_REQ  per-source byte; source k occupies bits [8k+7:8k].
- `i_req_last`  in  NUM_REQ  byte ends the source's message.
- `o_req_ready`  out  NUM_REQ  one-cycle accept pulse to the granted source.
- `o_grant`  out  NUM_REQ  one-hot owner of the transmitter; 0 when free.
- `o_tx_dv`  out  1  one-cycle start strobe to the TX core.
- `o_tx_byte`  out  8  byte to the TX core; registered and held until the next load.
- `i_tx_done`  in  1  TX core one-cycle pulse at the end of the stop bit.
- `o_busy`  out  1  state ≠ IDLE.
- `o_timeout`  out  1  one-cycle pulse when a lock is broken by timeout.

## Operation
- **States:** IDLE, LOAD, WAIT_DONE, HOLD.
- **IDLE:**
  - Round-robin search of `i_req_valid`, starting at pointer `ptr`.
  - On a hit at index g: latch g as the owner, latch its byte and its last flag, go to LOAD.
  - No request: stay in IDLE.
- **LOAD** (exactly 1 cycle): `o_tx_dv`=1 and `o_req_ready[g]`=1, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `i_tx_done`.
  - If the latched last flag is 1: go to IDLE and set `ptr` = (g+1) mod NUM_REQ.
  - Otherwise: go to HOLD.
- **HOLD:** only source g is considered.
  - `i_req_valid[g]`=1: latch its byte and last flag, go to LOAD.
  - Valid from other sources is ignored.
- **Source handshake:**
  - A source holds valid, byte and last stable until it sees its ready pulse.
  - Valid must be evaluated in the cycle it is sampled; a source may drop valid before being granted without penalty.
- **Reset values:**
  - Outputs: `o_req_ready`, `o_grant`, `o_tx_dv`, `o_tx_byte`, `o_busy` and `o_timeout` all reset to 0.
  - Internal: state = IDLE, `ptr` = 0, timeout counter = 0.
- **Boundaries:**
  - `i_tx_done` outside WAIT_DONE is ignored.
  - New valid in the same cycle as `i_tx_done` is not seen until IDLE or HOLD, the next cycle.
  - Reset mid-byte: all state is cleared immediately. The TX core shares `i_reset`, so no partial byte is resumed.
  - `ptr` wraps from NUM_REQ-1 to 0.
  - A single requester with repeated one-byte messages is re-granted every time.

## Timing
- Valid sampled in IDLE at cycle N → LOAD at N+1 (`o_tx_dv`, `o_req_ready`, `o_grant` all visible) → WAIT_DONE at N+2.
- `i_tx_done` at cycle M:
  - last=1: IDLE at M+1; earliest next LOAD at M+2.
  - last=0: HOLD at M+1; earliest next LOAD at M+2.
- `o_grant` is asserted from LOAD through the last WAIT_DONE cycle, and during HOLD.
- `o_tx_byte` changes only on entry to LOAD.

## Configuration
- **`UART_ARB_TIMEOUT_EN` defined:**
  - Counter increments each HOLD cycle where `i_req_valid[g]`=0, and clears on leaving HOLD.
  - At count = TIMEOUT_CYCLES-1: go to IDLE, rotate `ptr` past g, pulse `o_timeout`.
- **`UART_ARB_TIMEOUT_EN` undefined:**
  - No counter; HOLD waits indefinitely.
  - `o_timeout` is tied to 0 and the `TIMEOUT_CYCLES` parameter is unused.

## Structure
- **Package `uart_arb_pkg`:**
  - State enum (IDLE, LOAD, WAIT_DONE, HOLD).
  - `CLKS_PER_BIT` = 217.
  - Default `TIMEOUT_CYCLES` = 20*CLKS_PER_BIT.
- **Sub-module `uart_rr_picker`:** combinational one-hot round-robin select from (`i_req_valid`, `ptr`), also returning a found flag. The FSM, latches and counter stay in `uart_tx_arbiter`.

## Test plan
The bench uses a TX core model that pulses `i_tx_done` 10 cycles after `o_tx_dv`; all 2-source cases use NUM_REQ=2.
1. Reset → all outputs 0; src0 valid byte 8'h31 last=1 → `o_tx_dv` pulse with `o_tx_byte`=8'h31 one cycle after valid, `o_req_ready`=2'b01, IDLE after done.
2. Both sources valid with single-byte messages (8'h4A, 8'hFF) after reset → src0 served first, then src1, then src0 again; verifies `ptr` wrap.
3. src0 sends message 8'h12, 8'h34 (last); src1 valid throughout → src1 not granted until after 8'h34 done; `o_grant` stays 2'b01 across HOLD.
4. `i_reset` asserted 3 cycles into WAIT_DONE → next cycle state IDLE, `o_grant`=0, `ptr`=0, and a later `i_tx_done` pulse is ignored.
5. With `UART_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=16: src0 sends non-last 8'hAA then drops valid → `o_timeout` pulses after 16 HOLD cycles and src1 is granted next.
6. Without the macro, same stimulus as case 5 → HOLD persists for 1000 cycles and `o_timeout` stays 0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the UART TX arbiter.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_DONE = 2'd2,
      HOLD      = 2'd3
   } arb_state_t;

   localparam int CLKS_PER_BIT       = 217;
   // 20 bit times: how long a locked source may go quiet mid-message
   localparam int TIMEOUT_CYCLES_DEF = 20 * CLKS_PER_BIT;

endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational round-robin select. Scans i_valid starting
// at i_ptr and wrapping, returns the first hit as one-hot and as an index.
module uart_rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_sel,
   output logic [PTR_W-1:0]   o_idx,
   output logic               o_found
);

   logic [PTR_W:0] k;

   // first valid source at or after ptr, modulo NUM_REQ
   always_comb begin
      o_sel   = '0;
      o_idx   = '0;
      o_found = 1'b0;
      k       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k = {1'b0, i_ptr} + (PTR_W+1)'(i);
         if (k >= (PTR_W+1)'(NUM_REQ))
            k = k - (PTR_W+1)'(NUM_REQ);
         if (!o_found && i_valid[k[PTR_W-1:0]]) begin
            o_found              = 1'b1;
            o_idx                = k[PTR_W-1:0];
            o_sel[k[PTR_W-1:0]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX core between NUM_REQ byte sources.
// Round-robin between messages; a granted source keeps the transmitter
// until it sends a byte flagged last.
// Optional: define UART_ARB_TIMEOUT_EN to break a lock when the owner stays
// idle in HOLD for TIMEOUT_CYCLES cycles (pulses o_timeout).
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [8*NUM_REQ-1:0] i_req_byte,
   input  logic [NUM_REQ-1:0]   i_req_last,
   output logic [NUM_REQ-1:0]   o_req_ready,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic                 o_tx_dv,
   output logic [7:0]           o_tx_byte,
   input  logic                 i_tx_done,
   output logic                 o_busy,
   output logic                 o_timeout
);

   localparam int PTR_W = $clog2(NUM_REQ);

   arb_state_t         state, state_nxt;
   logic [PTR_W-1:0]   ptr, ptr_nxt, owner, pick_idx, load_idx;
   logic [NUM_REQ-1:0] owner_oh, pick_sel;
   logic               pick_found, owner_last, owner_valid;
   logic               load_en, release_lock, to_hit;

   uart_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
      .i_valid (i_req_valid),
      .i_ptr   (ptr),
      .o_sel   (pick_sel),
      .o_idx   (pick_idx),
      .o_found (pick_found)
   );

   // only the owner's valid matters once the message is locked
   assign owner_valid  = i_req_valid[owner];
   assign load_en      = ((state == IDLE) && pick_found) || ((state == HOLD) && owner_valid);
   assign load_idx     = (state == IDLE) ? pick_idx : owner;
   assign release_lock = ((state == WAIT_DONE) && i_tx_done && owner_last) || to_hit;
   assign ptr_nxt      = (owner == PTR_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES+1);
   logic [TO_W-1:0] to_cnt;

   assign to_hit = (state == HOLD) && !owner_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES-1));

   // count idle HOLD cycles; cleared whenever the FSM leaves HOLD
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         to_cnt    <= '0;
         o_timeout <= 1'b0;
      end else begin
         o_timeout <= to_hit;
         if (state_nxt != HOLD)
            to_cnt <= '0;
         else if ((state == HOLD) && !owner_valid)
            to_cnt <= to_cnt + 1'b1;
      end
   end
`else
   // no lock timeout in this build: HOLD waits for the owner indefinitely
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign to_hit             = 1'b0;
   assign o_timeout          = 1'b0;
`endif

   // next state and per-state outputs
   always_comb begin
      state_nxt   = state;
      o_tx_dv     = 1'b0;
      o_req_ready = '0;
      o_grant     = '0;
      o_busy      = 1'b1;
      case (state)
         IDLE: begin
            o_busy = 1'b0;
            if (pick_found) state_nxt = LOAD;
         end
         LOAD: begin
            o_tx_dv     = 1'b1;
            o_req_ready = owner_oh;
            o_grant     = owner_oh;
            state_nxt   = WAIT_DONE;
         end
         WAIT_DONE: begin
            o_grant = owner_oh;
            if (i_tx_done) state_nxt = owner_last ? IDLE : HOLD;
         end
         HOLD: begin
            o_grant = owner_oh;
            if (owner_valid)  state_nxt = LOAD;
            else if (to_hit)  state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state, owner/byte latches and round-robin pointer
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= IDLE;
         ptr        <= '0;
         owner      <= '0;
         owner_oh   <= '0;
         owner_last <= 1'b0;
         o_tx_byte  <= '0;
      end else begin
         state <= state_nxt;
         if (load_en) begin
            owner      <= load_idx;
            owner_last <= i_req_last[load_idx];
            o_tx_byte  <= i_req_byte[{load_idx, 3'b000} +: 8];
            if (state == IDLE) owner_oh <= pick_sel;
         end
         if (release_lock) ptr <= ptr_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a scoreboard of expected TX bytes
// and a TX core model that pulses i_tx_done 10 cycles after o_tx_dv.
// Case 5 runs when UART_ARB_TIMEOUT_EN is defined, case 6 otherwise.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 2;
   localparam int TO_CYC  = 16;

   logic               clk = 1'b0;
   logic               i_reset = 1'b1;
   logic [NUM_REQ-1:0] i_req_valid = '0;
   logic [15:0]        i_req_byte  = '0;
   logic [NUM_REQ-1:0] i_req_last  = '0;
   logic               i_tx_done   = 1'b0;
   logic [NUM_REQ-1:0] o_req_ready, o_grant;
   logic               o_tx_dv, o_busy, o_timeout;
   logic [7:0]         o_tx_byte;

   always #20 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_req_valid (i_req_valid),
      .i_req_byte  (i_req_byte),
      .i_req_last  (i_req_last),
      .o_req_ready (o_req_ready),
      .o_grant     (o_grant),
      .o_tx_dv     (o_tx_dv),
      .o_tx_byte   (o_tx_byte),
      .i_tx_done   (i_tx_done),
      .o_busy      (o_busy),
      .o_timeout   (o_timeout)
   );

   typedef struct {logic [7:0] b; logic last;} item_t;
   typedef struct {int src; logic [7:0] b;} exp_t;

   item_t sq0[$], sq1[$];
   exp_t  expq[$];
   int    checks = 0, errors = 0;
   int    done_cnt = 0;
   logic  core_en = 1'b1, stray = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int src, input logic [7:0] b, input logic last, input bit expect_tx);
      item_t it;
      it.b = b; it.last = last;
      if (src == 0) sq0.push_back(it); else sq1.push_back(it);
      if (expect_tx) expq.push_back('{src: src, b: b});
   endtask

   // one clock: sample at negedge, run core model and scoreboard, drive sources
   task automatic tick();
      exp_t e;
      @(negedge clk);
      i_tx_done = stray;
      stray     = 1'b0;
      if (done_cnt > 0) begin
         done_cnt--;
         if (done_cnt == 0) i_tx_done = 1'b1;
      end
      if (o_tx_dv === 1'b1) begin
         if (core_en) done_cnt = 10;
         checks++;
         assert (expq.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_dv: observed byte 'h%0h grant 'h%0h, expected no load", o_tx_byte, o_grant);
         end
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("sb_tx_byte", o_tx_byte, e.b);
            chk("sb_req_ready", o_req_ready, 32'(1) << e.src);
            chk("sb_grant", o_grant, 32'(1) << e.src);
         end
      end
      if (o_req_ready[0] === 1'b1 && sq0.size() > 0) void'(sq0.pop_front());
      if (o_req_ready[1] === 1'b1 && sq1.size() > 0) void'(sq1.pop_front());
      i_req_valid[0]   = (sq0.size() > 0);
      i_req_byte[7:0]  = (sq0.size() > 0) ? sq0[0].b : 8'h00;
      i_req_last[0]    = (sq0.size() > 0) ? sq0[0].last : 1'b0;
      i_req_valid[1]   = (sq1.size() > 0);
      i_req_byte[15:8] = (sq1.size() > 0) ? sq1[0].b : 8'h00;
      i_req_last[1]    = (sq1.size() > 0) ? sq1[0].last : 1'b0;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      repeat (2) tick();
      i_reset = 1'b0;
   endtask

   task automatic run_idle(input string tag, input int budget);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(o_busy === 1'b0 && sq0.size() == 0 && sq1.size() == 0 && expq.size() == 0) && n < budget);
      chk({tag, "_drained"}, (n < budget), 1);
   endtask

   initial begin
      int   n;
      logic ok;

      // case 1: reset values, single byte from src0
      repeat (3) tick();
      chk("rst_ready", o_req_ready, 0);
      chk("rst_grant", o_grant, 0);
      chk("rst_tx_dv", o_tx_dv, 0);
      chk("rst_tx_byte", o_tx_byte, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_timeout", o_timeout, 0);
      i_reset = 1'b0;
      push(0, 8'h31, 1'b1, 1);
      tick();
      tick();
      chk("c1_dv_latency", o_tx_dv, 1);
      repeat (10) tick();
      chk("c1_busy_until_done", o_busy, 1);
      tick();
      chk("c1_idle_after_done", o_busy, 0);
      chk("c1_grant_released", o_grant, 0);

      // case 2: both sources, round robin with pointer wrap
      do_reset();
      push(0, 8'h4A, 1'b1, 1);
      push(1, 8'hFF, 1'b1, 1);
      push(0, 8'h5A, 1'b1, 0);
      expq.push_back('{src: 0, b: 8'h5A});
      run_idle("c2", 200);

      // case 3: locked two-byte message from src0 while src1 waits
      do_reset();
      push(0, 8'h12, 1'b0, 1);
      push(0, 8'h34, 1'b1, 1);
      push(1, 8'hAB, 1'b1, 1);
      n = 0;
      do begin tick(); n++; end while (o_tx_dv !== 1'b1 && n < 20);
      chk("c3_first_dv", o_tx_dv, 1);
      ok = 1'b1;
      n  = 0;
      do begin
         tick();
         n++;
         if (o_grant !== 2'b01) ok = 1'b0;
      end while (o_tx_dv !== 1'b1 && n < 40);
      chk("c3_grant_locked", ok, 1);
      chk("c3_second_dv", o_tx_dv, 1);
      run_idle("c3", 200);

      // case 4: reset during WAIT_DONE, stray done ignored, ptr back to 0
      push(0, 8'h55, 1'b1, 1);
      run_idle("c4_pre", 100);
      core_en = 1'b0;
      push(1, 8'h66, 1'b1, 1);
      tick();
      tick();
      chk("c4_dv", o_tx_dv, 1);
      repeat (3) tick();
      i_reset = 1'b1;
      tick();
      chk("c4_rst_busy", o_busy, 0);
      chk("c4_rst_grant", o_grant, 0);
      chk("c4_rst_byte", o_tx_byte, 0);
      i_reset = 1'b0;
      stray   = 1'b1;
      tick();
      tick();
      chk("c4_stray_done_busy", o_busy, 0);
      chk("c4_stray_done_dv", o_tx_dv, 0);
      core_en = 1'b1;
      push(0, 8'h70, 1'b1, 1);
      push(1, 8'h71, 1'b1, 1);
      run_idle("c4", 200);

      // case 5/6: src0 sends non-last byte then goes quiet
`ifdef UART_ARB_TIMEOUT_EN
      push(0, 8'hAA, 1'b0, 1);
      push(1, 8'hBB, 1'b1, 1);
`else
      push(0, 8'hAA, 1'b0, 1);
      push(1, 8'hBB, 1'b1, 0);
`endif
      tick();
      tick();
      chk("c5_dv", o_tx_dv, 1);
`ifdef UART_ARB_TIMEOUT_EN
      repeat (26) tick();
      chk("c5_hold_busy", o_busy, 1);
      chk("c5_no_early_timeout", o_timeout, 0);
      tick();
      chk("c5_timeout_pulse", o_timeout, 1);
      chk("c5_idle_after_timeout", o_busy, 0);
      tick();
      chk("c5_src1_dv", o_tx_dv, 1);
      chk("c5_timeout_one_cycle", o_timeout, 0);
      run_idle("c5", 200);
`else
      ok = 1'b1;
      repeat (1000) begin
         tick();
         if (o_timeout !== 1'b0 || o_grant !== 2'b01 || o_busy !== 1'b1) ok = 1'b0;
      end
      chk("c6_hold_persists", ok, 1);
      sq1.delete();
      do_reset();
      chk("c6_sb_empty", expq.size(), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no completion, expected finish within 10000 cycles");
      $fatal(1);
   end

endmodule
